// File: rtl/mms_line_fill_unit_pkg.sv
// Shared types and constants for the line fill unit: cache address layout,
// line data shape, fill FSM states and the line base helper.
package mms_line_fill_unit_pkg;

  localparam int ADDR_WD      = 32;
  localparam int DATA_WD      = 32;
  localparam int CACHE_OFFSET = 4;
  localparam int CACHE_INDEX  = 8;
  localparam int CACHE_TAG    = ADDR_WD - CACHE_INDEX - CACHE_OFFSET;
  localparam int LINE_WORDS   = 2 ** (CACHE_OFFSET - 2);
  localparam int LINE_WD      = LINE_WORDS * DATA_WD;
  localparam int BASE_WD      = ADDR_WD - CACHE_OFFSET;
  localparam int WORD_IDX_WD  = CACHE_OFFSET - 2;

  // Byte address split into tag | index | offset.
  typedef struct packed {
    logic [CACHE_TAG-1:0]    tag;
    logic [CACHE_INDEX-1:0]  index;
    logic [CACHE_OFFSET-1:0] offset;
  } cache_a_t;

  // Word i of a line sits at bits [32i+31:32i].
  typedef logic [LINE_WORDS-1:0][DATA_WD-1:0] inst_set_t;
  typedef logic [LINE_WORDS-1:0][DATA_WD-1:0] line_data_t;

  typedef logic [WORD_IDX_WD-1:0] word_idx_t;

  localparam word_idx_t LAST_BEAT = word_idx_t'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fill_state_e;

  // Line-aligned part of an address: {tag, index}.
  function automatic logic [BASE_WD-1:0] line_base(input cache_a_t addr);
    return {addr.tag, addr.index};
  endfunction

endpackage

// File: rtl/mms_line_fill_unit_if.sv
// Bus bundles for the line fill unit: the cache-side line request/response
// channel and the word-wide memory beat channel.
interface mms_line_req_if;
  import mms_line_fill_unit_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_WD-1:0]   req_addr;
  logic                 req_we;
  line_data_t           req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  line_data_t           rsp_rdata;
  logic                 rsp_err;

  // Cache controller side.
  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Line fill unit side.
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface mms_mem_if;
  import mms_line_fill_unit_pkg::*;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_WD-1:0]   mem_req_addr;
  logic                 mem_req_we;
  logic [DATA_WD-1:0]   mem_req_wdata;
  logic                 mem_rsp_valid;
  logic [DATA_WD-1:0]   mem_rsp_data;
  logic                 mem_rsp_err;

  // Line fill unit side, issuing beats.
  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );

  // Backing memory side.
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/mms_line_fill_unit.sv
// Line fill unit: takes one 16-byte line read or writeback from the cache,
// runs it as four single-outstanding word beats on the memory bus, and
// returns the assembled line (reads) together with the OR of beat errors.
module mms_line_fill_unit
  import mms_line_fill_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mms_line_req_if.slave line,
  mms_mem_if.master     mem
);

  fill_state_e        state_q, state_d;
  logic [BASE_WD-1:0] base_q, base_d;
  word_idx_t          crit_q, crit_d;
  word_idx_t          cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  line_data_t         wdata_q, wdata_d;
  line_data_t         buf_q, buf_d;

  cache_a_t           req_a;
  word_idx_t          beat_word;
  logic               last_beat;
  logic               unused_offset_bits;

  assign req_a              = cache_a_t'(line.req_addr);
  assign unused_offset_bits = ^req_a.offset[1:0];

  // Reads wrap from the critical word; writes always climb from word 0.
  assign beat_word = we_q ? cnt_q : word_idx_t'(crit_q + cnt_q);
  assign last_beat = (cnt_q == LAST_BEAT);

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, beat counter, line buffer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      crit_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      base_q  <= base_d;
      crit_q  <= crit_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state: one beat outstanding at a time, responses only heard in WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (line.req_valid)     state_d = ISSUE;
      ISSUE: if (mem.mem_req_ready)  state_d = WAIT;
      WAIT:  if (mem.mem_rsp_valid)  state_d = last_beat ? RESP : ISSUE;
      RESP:  if (line.rsp_ready)     state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Datapath updates: capture on accept, fill by line index on each response.
  always_comb begin
    base_d  = base_q;
    crit_d  = crit_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (line.req_valid) begin
          base_d  = line_base(req_a);
          crit_d  = req_a.offset[CACHE_OFFSET-1:2];
          we_d    = line.req_we;
          wdata_d = line.req_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          buf_d   = '0;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          if (!we_q) begin
            buf_d[beat_word] = mem.mem_rsp_data;
          end
          err_d = err_q | mem.mem_rsp_err;
          if (!last_beat) begin
            cnt_d = word_idx_t'(cnt_q + word_idx_t'(1));
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; buses are held quiet outside their phase.
  always_comb begin
    line.req_ready    = 1'b0;
    line.rsp_valid    = 1'b0;
    line.rsp_rdata    = '0;
    line.rsp_err      = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_wdata = '0;
    unique case (state_q)
      IDLE: begin
        line.req_ready = 1'b1;
      end
      ISSUE: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = {base_q, beat_word, 2'b00};
        mem.mem_req_we    = we_q;
        mem.mem_req_wdata = wdata_q[beat_word];
      end
      RESP: begin
        line.rsp_valid = 1'b1;
        line.rsp_rdata = buf_q;
        line.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
